// File: rtl/counter_clear_up_pkg.sv
// -----------------------------------------------------------------------------
// counter_clear_up_pkg
// Shared definitions for counter_clear_up and the monitors built on it.
//   next_sel_e : next-state source for a clearable up-counter, listed in
//                priority order (reset, clear, up, hold).
//   next_sel() : maps the control inputs onto next_sel_e so that every
//                user resolves the priority the same way.
// -----------------------------------------------------------------------------
package counter_clear_up_pkg;

  typedef enum logic [1:0] {
    NS_RESET = 2'd0,
    NS_CLEAR = 2'd1,
    NS_UP    = 2'd2,
    NS_HOLD  = 2'd3
  } next_sel_e;

  function automatic next_sel_e next_sel(input logic reset,
                                         input logic clear,
                                         input logic up);
    next_sel_e sel;
    if (reset)      sel = NS_RESET;
    else if (clear) sel = NS_CLEAR;
    else if (up)    sel = NS_UP;
    else            sel = NS_HOLD;
    return sel;
  endfunction

endpackage

// File: rtl/counter_clear_up_dff_set_clear.sv
// -----------------------------------------------------------------------------
// dff_set_clear
// Bank of width_p sticky bits. A set bit stays set until cleared or reset.
// Parameters:
//   width_p          number of bits
//   clear_over_set_p 1: clear wins when set and clear are both active
//                    0: set wins
// Ports:
//   clk_i    in  1        clock
//   reset_i  in  1        synchronous active-high reset, clears all bits
//   set_i    in  width_p  per-bit set
//   clear_i  in  width_p  per-bit clear
//   data_o   out width_p  registered sticky bits
// -----------------------------------------------------------------------------
module dff_set_clear #(
  parameter int width_p          = 1,
  parameter bit clear_over_set_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] set_i,
  input  logic [width_p-1:0] clear_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_d;
  logic [width_p-1:0] data_q;

  if (clear_over_set_p) begin : g_clear_wins
    always_comb begin
      data_d = (data_q | set_i) & ~clear_i;
    end
  end else begin : g_set_wins
    always_comb begin
      data_d = (data_q & ~clear_i) | set_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/counter_clear_up.sv
// -----------------------------------------------------------------------------
// counter_clear_up
// Up-counter with synchronous clear and increment enable, plus a registered
// sticky hit flag that latches one cycle after the count equals target_i.
// Intended for perf/finish monitors (count instructions or cycles and flag
// when a runtime target is reached).
//
// Parameters:
//   max_val_p   largest count value (sets the width)
//   init_val_p  count value loaded on reset, must be <= max_val_p
//   width_lp    $clog2(max_val_p+1), minimum 1
// Ports:
//   clk_i     in  1         clock
//   reset_i   in  1         synchronous active-high reset (highest priority)
//   clear_i   in  1         synchronous clear of count and hit flag
//   up_i      in  1         increment enable
//   target_i  in  width_lp  hit compare value; 0 disables the hit flag
//   count_o   out width_lp  registered count
//   hit_o     out 1         registered sticky hit flag
//
// Build option:
//   COUNTER_CLEAR_UP_SATURATE_EN  defined: increment at max_val_p holds the
//                                 count at max_val_p; undefined (default):
//                                 the count wraps to 0.
// -----------------------------------------------------------------------------
module counter_clear_up
  import counter_clear_up_pkg::*;
#(
  parameter  int max_val_p  = 255,
  parameter  int init_val_p = 0,
  localparam int width_lp   = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  input  logic [width_lp-1:0] target_i,
  output logic [width_lp-1:0] count_o,
  output logic                hit_o
);

  if (init_val_p > max_val_p) begin : g_bad_init
    $error("counter_clear_up: init_val_p (%0d) exceeds max_val_p (%0d)",
           init_val_p, max_val_p);
  end

  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);
  localparam logic [width_lp-1:0] one_lp  = width_lp'(1);

  // Value taken by an increment issued while the count sits at max_val_p.
`ifdef COUNTER_CLEAR_UP_SATURATE_EN
  localparam logic [width_lp-1:0] at_max_lp = max_lp;
`else
  localparam logic [width_lp-1:0] at_max_lp = '0;
`endif

  next_sel_e           sel;
  logic [width_lp-1:0] count_d;
  logic [width_lp-1:0] count_q;
  logic                match;

  always_comb begin
    sel     = next_sel(reset_i, clear_i, up_i);
    count_d = count_q;
    unique case (sel)
      NS_RESET: count_d = init_lp;
      // A clear that coincides with an increment counts that increment.
      NS_CLEAR: count_d = up_i ? one_lp : '0;
      // Explicit compare rather than natural overflow: max_val_p need not
      // be a power of two minus one.
      NS_UP:    count_d = (count_q == max_lp) ? at_max_lp : count_q + one_lp;
      NS_HOLD:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= init_lp;
    else         count_q <= count_d;
  end

  // Compared against the registered count, so hit_o trails by one cycle.
  assign match = (count_q == target_i) && (target_i != '0);

  dff_set_clear #(
    .width_p          (1),
    .clear_over_set_p (1'b1)
  ) u_hit (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (match),
    .clear_i (clear_i),
    .data_o  (hit_o)
  );

  assign count_o = count_q;

endmodule

// File: tb/tb_counter_clear_up.sv
// -----------------------------------------------------------------------------
// tb_counter_clear_up
// Directed scenarios followed by a randomized run, every cycle compared
// against a behavioural model of the counter and hit flag.
// -----------------------------------------------------------------------------
module tb_counter_clear_up;

  localparam int MAX  = 15;
  localparam int INIT = 5;
  localparam int W    = 4;
`ifdef COUNTER_CLEAR_UP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         reset_i;
  logic         clear_i;
  logic         up_i;
  logic [W-1:0] target_i;
  logic [W-1:0] count_o;
  logic         hit_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_count;
  int m_hit;

  counter_clear_up #(
    .max_val_p  (MAX),
    .init_val_p (INIT)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .clear_i  (clear_i),
    .up_i     (up_i),
    .target_i (target_i),
    .count_o  (count_o),
    .hit_o    (hit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same cycle and
  // compare both outputs just after the clock edge.
  task automatic step(input bit r, input bit c, input bit u, input int t);
    int nc;
    int nh;
    reset_i  = r;
    clear_i  = c;
    up_i     = u;
    target_i = t[W-1:0];
    if (r) begin
      nc = INIT;
      nh = 0;
    end else begin
      if (c)      nc = u ? 1 : 0;
      else if (u) nc = SAT ? ((m_count + 1 > MAX) ? MAX : m_count + 1)
                           : (m_count + 1) % (MAX + 1);
      else        nc = m_count;
      if (c)                             nh = 0;
      else if (t != 0 && m_count == t)   nh = 1;
      else                               nh = m_hit;
    end
    @(posedge clk);
    #1;
    m_count = nc;
    m_hit   = nh;
    chk("model_count", count_o, m_count);
    chk("model_hit", hit_o, m_hit);
  endtask

  initial begin
    clk      = 1'b0;
    reset_i  = 1'b0;
    clear_i  = 1'b0;
    up_i     = 1'b0;
    target_i = '0;
    m_count  = 0;
    m_hit    = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset loads init value, then idle holds it
    step(1, 0, 0, 0);
    chk("reset_count", count_o, INIT);
    chk("reset_hit", hit_o, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("idle_hold_count", count_o, INIT);

    // Count to target 10, hit one cycle later and sticky afterwards
    step(0, 1, 0, 10);
    chk("clear_to_zero", count_o, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 10);
    chk("count_at_target", count_o, 10);
    chk("hit_not_yet", hit_o, 0);
    step(0, 0, 1, 10);
    chk("count_11", count_o, 11);
    chk("hit_rises", hit_o, 1);
    step(0, 0, 1, 10);
    chk("count_12", count_o, 12);
    chk("hit_sticky", hit_o, 1);

    // Clear vs up at count 7
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    chk("count_7a", count_o, 7);
    step(0, 1, 0, 0);
    chk("clear_no_up", count_o, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    chk("count_7b", count_o, 7);
    step(0, 1, 1, 0);
    chk("clear_with_up", count_o, 1);

    // Clear in the same cycle as a match keeps hit low
    step(0, 1, 0, 7);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 7);
    chk("count_7c", count_o, 7);
    step(0, 1, 0, 7);
    chk("clear_beats_match", hit_o, 0);
    step(0, 0, 0, 7);
    chk("clear_beats_match_after", hit_o, 0);

    // Target zero never sets hit, even sitting at 0
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("target0_count", count_o, 0);
    chk("target0_hit", hit_o, 0);

    // Increment at max: wrap or saturate
    for (int i = 0; i < MAX; i++) step(0, 0, 1, 0);
    chk("count_max", count_o, MAX);
    step(0, 0, 1, 0);
    chk("count_past_max", count_o, SAT ? MAX : 0);

    // Mid-run reset with hit set
    step(0, 1, 0, 9);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 9);
    step(0, 0, 0, 9);
    chk("pre_reset_count", count_o, 9);
    chk("pre_reset_hit", hit_o, 1);
    step(1, 0, 0, 9);
    chk("midrun_reset_count", count_o, INIT);
    chk("midrun_reset_hit", hit_o, 0);

    // Randomized run
    begin
      int tgt;
      tgt = 0;
      for (int i = 0; i < 600; i++) begin
        int r;
        bit rb;
        bit cb;
        bit ub;
        r  = int'($urandom_range(0, 99));
        rb = (r < 2);
        cb = (int'($urandom_range(0, 99)) < 8);
        ub = (int'($urandom_range(0, 99)) < 75);
        if ($urandom_range(0, 19) == 0) tgt = int'($urandom_range(0, MAX));
        step(rb, cb, ub, tgt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
